vga_timing_gen: RTL

VGA raster timing generator for the 640x480 @ 60 Hz display path. It runs free-running horizontal and vertical counters on the pixel clock and produces DrawX/DrawY, blank, hs and vs. It sits directly upstream of the image/palette stages, which turn DrawX/DrawY into ROM addresses and gate their colour output with blank. It also provides a one-cycle frame_start pulse for frame-synchronous logic such as game-state update.

---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered blank, sync and frame-start.
// Optional macro VGA_SYNC_DELAY_EN delays hs/vs by two clocks to line up with the image-stage pipeline.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // Window compares are done one bit wider so an end bound of 1024 does not wrap.
    function automatic logic in_window(input logic [9:0] pos, input logic [10:0] lo,
                                       input logic [10:0] hi);
        return ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
    endfunction

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       hs_p0;
    logic       vs_p0;

    always_comb begin
        next_x = DrawX + 10'd1;
        next_y = DrawY;
        if (DrawX == H_LAST) begin
            next_x = '0;
            next_y = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Stage p0: flags decoded from the next counter values so they match the pixel being presented.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
        end else begin
            DrawX       <= next_x;
            DrawY       <= next_y;
            blank       <= ({1'b0, next_x} < H_VIS) && ({1'b0, next_y} < V_VIS);
            frame_start <= (next_x == 10'd0) && (next_y == 10'd0);
            hs_p0       <= !in_window(next_x, HS_START, HS_END);
            vs_p0       <= !in_window(next_y, VS_START, VS_END);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_p1;
    logic hs_p2;
    logic vs_p1;
    logic vs_p2;

    // Stages p1/p2: sync lags the counters to cover ROM read plus colour register downstream.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_p1 <= 1'b1;
            hs_p2 <= 1'b1;
            vs_p1 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p1 <= hs_p0;
            hs_p2 <= hs_p1;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
        end
    end

    assign hs = hs_p2;
    assign vs = vs_p2;
`else
    assign hs = hs_p0;
    assign vs = vs_p0;
`endif

endmodule
